cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
- Miss handler sitting directly downstream of the tag compare / way select stage.
- On a lookup miss it picks a victim way and fetches the full cache line from the memory bus as single-word reads.
- It writes each returned word into the data SRAM of the victim way, then writes the tag SRAM entry with its valid bit set.
- The lookup pipeline is stalled for the whole refill.

Parameters:
- NUM_WAYS, 1, number of ways; power of two, at least 1
- ADDR_WIDTH, 32, word address width
- DATA_WIDTH, 32, data word width
- CLINE_SIZE_WORD, 4, words per line; power of two, at least 2
- CLINE_ADDR_WIDTH, 7, line index width
- TAG_SRAM_DATA_WIDTH, 32, tag entry width; tag in bits [TAG_WIDTH-1:0], valid at bit TAG_SRAM_DATA_WIDTH-1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- miss_i  in  1  lookup valid and hit_o low this cycle
- addr_i  in  ADDR_WIDTH  missing word address; sampled with miss_i
- way_valid_i  in  NUM_WAYS  valid bits of the indexed set; sampled with miss_i
- busy_o  out  1  refill in progress; stalls lookup
- done_o  out  1  one-cycle pulse when the tag write completes
- mem_req_o  out  1  bus read request
- mem_addr_o  out  ADDR_WIDTH  bus word address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid; responses return in order
- mem_rdata_i  in  DATA_WIDTH  read data
- data_we_o  out  1  data SRAM write enable
- data_way_o  out  NUM_WAYS  one-hot way select
- data_addr_o  out  CLINE_ADDR_WIDTH+log2(CLINE_SIZE_WORD)  {index, word}
- data_wdata_o  out  DATA_WIDTH  write data
- tag_we_o  out  1  tag SRAM write enable
- tag_way_o  out  NUM_WAYS  one-hot way select
- tag_addr_o  out  CLINE_ADDR_WIDTH  set index
- tag_wdata_o  out  TAG_SRAM_DATA_WIDTH  {1'b1, zero pad, tag}

Behaviour:
Address fields:
- word = addr[W-1:0], with W = log2(CLINE_SIZE_WORD)
- index = addr[W+:CLINE_ADDR_WIDTH]
- tag = addr[TAG_OFFSET+:TAG_WIDTH], with TAG_OFFSET = W+CLINE_ADDR_WIDTH and TAG_WIDTH = ADDR_WIDTH-TAG_OFFSET

Reset:
- All outputs 0; FSM goes to IDLE; round-robin pointer rr_q = 0.
- Reset mid-refill aborts immediately. Later bus responses are not counted; the bus resets on the same rst_i.

FSM states:
- IDLE: miss_i=1 captures addr, index, tag and victim; go to FILL next cycle. busy_o=1 from that cycle.
- FILL: two counters run, each 0..CLINE_SIZE_WORD-1 with W-bit wrap.
  - req_cnt: mem_req_o=1 while req_cnt < CLINE_SIZE_WORD; mem_addr_o = {line base, req word}; increments on mem_gnt_i.
  - rsp_cnt: each mem_rvalid_i writes one word: data_we_o=1 the same cycle, data_wdata_o=mem_rdata_i, data_addr_o={index, rsp word}; increments rsp_cnt.
  - A grant and a response in the same cycle are both counted, including zero-latency responses.
  - mem_req_o holds with a stable address until granted.
  - Last response goes to TAG.
- TAG: tag_we_o=1 for exactly one cycle; go to DONE.
- DONE: done_o=1 for one cycle; busy_o=0 in DONE; return to IDLE.
- Refill latency is at least CLINE_SIZE_WORD+3 cycles from the miss_i cycle to the done_o cycle.

Victim selection:
- Lowest-index way with way_valid_i=0.
- If all ways are valid, use rr_q; rr_q increments mod NUM_WAYS only when it was the chosen victim.
- NUM_WAYS=1: always way 0.

Ordering and stall rules:
- Tag is written last, so the line never appears valid with partial data.
- miss_i while busy_o=1 is ignored.
- mem_rvalid_i in IDLE or TAG is ignored.

Optional Feature:
Macro CACHE_REFILL_CRITICAL_WORD_FIRST_EN.
- Defined:
  - The request sequence starts at the missing word and wraps mod CLINE_SIZE_WORD.
  - Extra outputs fwd_valid_o (1) and fwd_data_o (DATA_WIDTH) pulse with the first response, so the core can restart early.
  - Data SRAM addresses follow the same wrapped order.
- Undefined:
  - The request sequence starts at word 0.
  - Forwarding ports are absent.

Decomposition:
- Package cache_pkg holds:
  - refill_state_e (IDLE, FILL, TAG, DONE)
  - helper functions for the tag offset and tag width
  - the TAG_VALID_BIT position
- Sub-module cache_victim_sel: combinational lowest-invalid priority pick plus the rr_q register and its update.

Test Plan:
Common setup: NUM_WAYS=2, CLINE_SIZE_WORD=4, CLINE_ADDR_WIDTH=7, 1-cycle grant, 2-cycle response latency.
1. Basic refill: miss_i with addr 0x1234 and way_valid_i=2'b00 -> mem_addr_o sequence 0x1234, 0x1235, 0x1236, 0x1237; data_way_o=01; data_addr_o=0x34..0x37; then tag_we_o with tag_addr_o=0x0D, tag_wdata_o=0x8000_0009; then done_o pulse.
2. Victim selection: way_valid_i=2'b01 -> way 1. Then two misses with 2'b11 -> ways 0 then 1 (rr_q wraps).
3. Bus backpressure: mem_gnt_i held low 5 cycles -> mem_req_o and mem_addr_o stable; no data_we_o; refill completes afterwards.
4. Zero-latency responses (rvalid in the grant cycle) -> exactly 4 data writes, in order.
5. rst_i after 2 responses -> next cycle all outputs 0 and busy_o=0; a stale rvalid produces no write; a fresh miss refills correctly.
6. Critical word first (macro defined): addr 0x1236 -> request sequence 0x1236, 0x1237, 0x1234, 0x1235; fwd_valid_o with the first word's data.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and address-field helpers for the cache refill controller
// Contents: refill_state_e FSM encoding; tag_offset/tag_width address split helpers;
// tag_valid_bit giving the valid flag position inside a tag SRAM entry.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2,
        DONE = 2'd3
    } refill_state_e;

    // Tag starts right above the word-in-line and set-index fields.
    function automatic int tag_offset(input int word_bits, input int index_bits);
        return word_bits + index_bits;
    endfunction

    function automatic int tag_width(input int addr_width, input int offset);
        return addr_width - offset;
    endfunction

    // Valid flag sits in the MSB of the tag entry.
    function automatic int tag_valid_bit(input int entry_width);
        return entry_width - 1;
    endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// rtl/cache_victim_sel.sv - victim way picker: lowest invalid way, else round-robin pointer
// Ports: clk_i/rst_i clock and sync active-high reset; way_valid_i set valid bits;
// take_i pick is consumed this cycle; victim_o one-hot victim way.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_WAYS-1:0] way_valid_i,
    input  logic                take_i,
    output logic [NUM_WAYS-1:0] victim_o
);

    localparam int RR_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(NUM_WAYS - 1);

    logic [RR_W-1:0] r_rr;
    logic            w_found;

    always_comb begin
        victim_o = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!way_valid_i[i] && !w_found) begin
                victim_o[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
        if (!w_found) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                victim_o[i] = (r_rr == RR_W'(i));
            end
        end
    end

    // The pointer only advances when it actually supplied the victim,
    // so filling invalid ways does not disturb the rotation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr <= '0;
        end else if (take_i && !w_found) begin
            r_rr <= (r_rr == RR_LAST) ? '0 : r_rr + 1'b1;
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - cache line refill controller: fetch line word by word, write data then tag
// Ports: clk_i/rst_i clock and sync active-high reset; miss_i/addr_i/way_valid_i miss request;
// busy_o/done_o stall and completion; mem_* single-word read bus; data_* data SRAM write port;
// tag_* tag SRAM write port; fwd_valid_o/fwd_data_o first returned word (macro only).
// Option: define CACHE_REFILL_CRITICAL_WORD_FIRST_EN to fetch the missing word first.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_WAYS            = 1,
    parameter int ADDR_WIDTH          = 32,
    parameter int DATA_WIDTH          = 32,
    parameter int CLINE_SIZE_WORD     = 4,
    parameter int CLINE_ADDR_WIDTH    = 7,
    parameter int TAG_SRAM_DATA_WIDTH = 32
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    input  logic                                                 miss_i,
    input  logic [ADDR_WIDTH-1:0]                                addr_i,
    input  logic [NUM_WAYS-1:0]                                  way_valid_i,
    output logic                                                 busy_o,
    output logic                                                 done_o,
    output logic                                                 mem_req_o,
    output logic [ADDR_WIDTH-1:0]                                mem_addr_o,
    input  logic                                                 mem_gnt_i,
    input  logic                                                 mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                                mem_rdata_i,
    output logic                                                 data_we_o,
    output logic [NUM_WAYS-1:0]                                  data_way_o,
    output logic [CLINE_ADDR_WIDTH+$clog2(CLINE_SIZE_WORD)-1:0] data_addr_o,
    output logic [DATA_WIDTH-1:0]                                data_wdata_o,
    output logic                                                 tag_we_o,
    output logic [NUM_WAYS-1:0]                                  tag_way_o,
    output logic [CLINE_ADDR_WIDTH-1:0]                          tag_addr_o,
    output logic [TAG_SRAM_DATA_WIDTH-1:0]                       tag_wdata_o
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    ,
    output logic                                                 fwd_valid_o,
    output logic [DATA_WIDTH-1:0]                                fwd_data_o
`endif
);

    localparam int W             = $clog2(CLINE_SIZE_WORD);
    localparam int TAG_OFFSET    = tag_offset(W, CLINE_ADDR_WIDTH);
    localparam int TAG_WIDTH     = tag_width(ADDR_WIDTH, TAG_OFFSET);
    localparam int TAG_VALID_BIT = tag_valid_bit(TAG_SRAM_DATA_WIDTH);
    localparam logic [W-1:0] LAST_WORD = W'(CLINE_SIZE_WORD - 1);

    refill_state_e                r_state;
    refill_state_e                w_state_nxt;
    logic [TAG_WIDTH-1:0]         r_tag;
    logic [CLINE_ADDR_WIDTH-1:0]  r_index;
    logic [W-1:0]                 r_start;
    logic [NUM_WAYS-1:0]          r_way;
    logic [W-1:0]                 r_req_cnt;
    logic [W-1:0]                 r_rsp_cnt;
    logic                         r_req_done;   // all words granted; req_cnt has wrapped to 0

    logic                         w_accept;
    logic [NUM_WAYS-1:0]          w_victim;
    logic [W-1:0]                 w_req_word;
    logic [W-1:0]                 w_rsp_word;
    logic                         w_unused_word;

    // DONE already has busy_o low, so a miss presented there is taken
    // rather than dropped.
    assign w_accept   = miss_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_req_word = r_start + r_req_cnt;
    assign w_rsp_word = r_start + r_rsp_cnt;
    // Word offset of the miss only steers ordering in critical-word-first builds.
    assign w_unused_word = ^addr_i[W-1:0];

    cache_victim_sel #(
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_sel (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .way_valid_i (way_valid_i),
        .take_i      (w_accept),
        .victim_o    (w_victim)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_tag      <= '0;
            r_index    <= '0;
            r_start    <= '0;
            r_way      <= '0;
            r_req_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_req_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tag      <= addr_i[TAG_OFFSET +: TAG_WIDTH];
                r_index    <= addr_i[W +: CLINE_ADDR_WIDTH];
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
                r_start    <= addr_i[W-1:0];
`else
                r_start    <= '0;
`endif
                r_way      <= w_victim;
                r_req_cnt  <= '0;
                r_rsp_cnt  <= '0;
                r_req_done <= 1'b0;
            end else if (r_state == FILL) begin
                // Grant and response counters move independently so a
                // response landing in its own grant cycle is still counted.
                if (!r_req_done && mem_gnt_i) begin
                    r_req_cnt <= r_req_cnt + 1'b1;
                    if (r_req_cnt == LAST_WORD) begin
                        r_req_done <= 1'b1;
                    end
                end
                if (mem_rvalid_i) begin
                    r_rsp_cnt <= r_rsp_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        data_we_o    = 1'b0;
        data_way_o   = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        tag_we_o     = 1'b0;
        tag_way_o    = '0;
        tag_addr_o   = '0;
        tag_wdata_o  = '0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        fwd_valid_o  = 1'b0;
        fwd_data_o   = '0;
`endif
        case (r_state)
            IDLE: begin
                if (miss_i) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                busy_o = 1'b1;
                if (!r_req_done) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = {r_tag, r_index, w_req_word};
                end
                if (mem_rvalid_i) begin
                    data_we_o    = 1'b1;
                    data_way_o   = r_way;
                    data_addr_o  = {r_index, w_rsp_word};
                    data_wdata_o = mem_rdata_i;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
                    fwd_valid_o  = (r_rsp_cnt == '0);
                    fwd_data_o   = (r_rsp_cnt == '0) ? mem_rdata_i : '0;
`endif
                    if (r_rsp_cnt == LAST_WORD) begin
                        w_state_nxt = TAG;
                    end
                end
            end
            TAG: begin
                // Tag goes last so the line only turns valid once every word is in.
                busy_o                     = 1'b1;
                tag_we_o                   = 1'b1;
                tag_way_o                  = r_way;
                tag_addr_o                 = r_index;
                tag_wdata_o[TAG_VALID_BIT] = 1'b1;
                tag_wdata_o[TAG_WIDTH-1:0] = r_tag;
                w_state_nxt                = DONE;
            end
            DONE: begin
                done_o      = 1'b1;
                w_state_nxt = miss_i ? FILL : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - self-checking bench for cache_refill_ctrl (2 ways, 4-word lines)
module tb_cache_refill_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        miss_i;
    logic [31:0] addr_i;
    logic [1:0]  way_valid_i;
    logic        busy_o, done_o, mem_req_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_rdata_i, data_wdata_o, tag_wdata_o;
    logic        data_we_o, tag_we_o;
    logic [1:0]  data_way_o, tag_way_o;
    logic [8:0]  data_addr_o;
    logic [6:0]  tag_addr_o;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic        fwd_valid_o;
    logic [31:0] fwd_data_o;
`endif

    cache_refill_ctrl #(
        .NUM_WAYS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .CLINE_SIZE_WORD(4), .CLINE_ADDR_WIDTH(7), .TAG_SRAM_DATA_WIDTH(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .miss_i(miss_i), .addr_i(addr_i),
        .way_valid_i(way_valid_i), .busy_o(busy_o), .done_o(done_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .data_we_o(data_we_o), .data_way_o(data_way_o), .data_addr_o(data_addr_o),
        .data_wdata_o(data_wdata_o), .tag_we_o(tag_we_o), .tag_way_o(tag_way_o),
        .tag_addr_o(tag_addr_o), .tag_wdata_o(tag_wdata_o)
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        , .fwd_valid_o(fwd_valid_o), .fwd_data_o(fwd_data_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  wv;
        int          lat;
        logic        noise;
        logic [1:0]  exp_way;
        logic [6:0]  exp_index;
        logic [31:0] exp_tagw;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;

    vec_t        vecs[7];
    pend_t       pend_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat = 2;
    logic        force_stall = 1'b0;

    logic [31:0] req_log[16];
    logic [8:0]  wr_addr[16];
    logic [31:0] wr_data[16];
    logic [1:0]  wr_way[16];
    int          req_n, wr_n, tag_n, done_n, fwd_n, busy_gap, miss_cyc, done_cyc;
    logic [6:0]  tag_addr_s;
    logic [31:0] tag_wdata_s, fwd_data_s;
    logic [1:0]  tag_way_s;
    logic        s_busy, s_req, s_we, s_done_busy;
    logic [31:0] s_maddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: bus model drives gnt/rvalid, outputs are sampled, then the edge passes.
    task automatic cycle();
        pend_t p;
        mem_gnt_i = mem_req_o && !force_stall;
        if (mem_gnt_i) begin
            p.due  = cyc + lat;
            p.addr = mem_addr_o;
            pend_q.push_back(p);
        end
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end
        #1;
        s_busy  = busy_o;
        s_req   = mem_req_o;
        s_maddr = mem_addr_o;
        s_we    = data_we_o;
        if (data_we_o && wr_n < 16) begin
            wr_addr[wr_n] = data_addr_o;
            wr_data[wr_n] = data_wdata_o;
            wr_way[wr_n]  = data_way_o;
            wr_n++;
        end
        if (mem_gnt_i && mem_req_o && req_n < 16) begin
            req_log[req_n] = mem_addr_o;
            req_n++;
        end
        if (tag_we_o) begin
            tag_n++;
            tag_addr_s  = tag_addr_o;
            tag_wdata_s = tag_wdata_o;
            tag_way_s   = tag_way_o;
        end
        if (done_o) begin
            done_n++;
            done_cyc    = cyc;
            s_done_busy = busy_o;
        end
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        if (fwd_valid_o) begin
            fwd_n++;
            fwd_data_s = fwd_data_o;
        end
`endif
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic start_miss(input logic [31:0] a, input logic [1:0] wv);
        req_n = 0; wr_n = 0; tag_n = 0; done_n = 0; fwd_n = 0; busy_gap = 0;
        pend_q.delete();
        addr_i      = a;
        way_valid_i = wv;
        miss_i      = 1'b1;
        miss_cyc    = cyc;
        cycle();
        miss_i      = 1'b0;
        way_valid_i = 2'b00;
    endtask

    // noise: hold a foreign miss during the first FILL cycles; it must be ignored.
    task automatic run_to_done(input logic noise);
        for (int i = 0; i < 60 && done_n == 0; i++) begin
            if (noise && i < 3) begin
                miss_i = 1'b1;
                addr_i = 32'hDEAD_BEE0;
            end else begin
                miss_i = 1'b0;
            end
            cycle();
            if (done_n == 0 && !s_busy) busy_gap++;
        end
        miss_i = 1'b0;
        cycle();
    endtask

    task automatic verify(input int vi, input vec_t v);
        logic [1:0]  start;
        logic [1:0]  wd;
        logic [31:0] ea;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        start = v.addr[1:0];
`else
        start = 2'd0;
`endif
        check($sformatf("v%0d_req_count", vi), req_n, 4);
        check($sformatf("v%0d_write_count", vi), wr_n, 4);
        for (int k = 0; k < 4; k++) begin
            wd = start + 2'(k);
            ea = {v.addr[31:2], wd};
            check($sformatf("v%0d_req_addr%0d", vi, k), req_log[k], ea);
            check($sformatf("v%0d_data_addr%0d", vi, k), wr_addr[k], {v.exp_index, wd});
            check($sformatf("v%0d_data_wdata%0d", vi, k), wr_data[k], mem_word(ea));
            check($sformatf("v%0d_data_way%0d", vi, k), wr_way[k], v.exp_way);
        end
        check($sformatf("v%0d_tag_we_count", vi), tag_n, 1);
        check($sformatf("v%0d_tag_addr", vi), tag_addr_s, v.exp_index);
        check($sformatf("v%0d_tag_wdata", vi), tag_wdata_s, v.exp_tagw);
        check($sformatf("v%0d_tag_way", vi), tag_way_s, v.exp_way);
        check($sformatf("v%0d_done_pulses", vi), done_n, 1);
        check($sformatf("v%0d_busy_in_done", vi), s_done_busy, 0);
        check($sformatf("v%0d_busy_gaps", vi), busy_gap, 0);
        check($sformatf("v%0d_latency_ge7", vi), (done_cyc - miss_cyc + 1) >= 7, 1);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1234, 2'b00, 2, 1'b0, 2'b01, 7'h0D, 32'h8000_0009};
        vecs[1] = '{32'h0000_ABC8, 2'b01, 2, 1'b1, 2'b10, 7'h72, 32'h8000_0055};
        vecs[2] = '{32'hFFFF_FFFC, 2'b11, 2, 1'b0, 2'b01, 7'h7F, 32'h807F_FFFF};
        vecs[3] = '{32'h0000_0200, 2'b11, 0, 1'b0, 2'b10, 7'h00, 32'h8000_0001};
        vecs[4] = '{32'h0000_0008, 2'b11, 1, 1'b0, 2'b01, 7'h02, 32'h8000_0000};
        vecs[5] = '{32'h0000_1236, 2'b10, 2, 1'b0, 2'b01, 7'h0D, 32'h8000_0009};
        vecs[6] = '{32'h0000_4321, 2'b11, 2, 1'b0, 2'b01, 7'h48, 32'h8000_0021};

        rst_i = 1'b1; miss_i = 1'b0; addr_i = '0; way_valid_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_outputs_or", |{done_o, mem_req_o, mem_addr_o, data_we_o, data_way_o,
              data_addr_o, data_wdata_o, tag_we_o, tag_way_o, tag_addr_o, tag_wdata_o}, 0);
        rst_i = 1'b0;

        for (int vi = 0; vi < 6; vi++) begin
            lat = vecs[vi].lat;
            start_miss(vecs[vi].addr, vecs[vi].wv);
            run_to_done(vecs[vi].noise);
            verify(vi, vecs[vi]);
        end

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
        check("cwf_req0", req_log[0], 32'h0000_1236);
        check("cwf_req1", req_log[1], 32'h0000_1237);
        check("cwf_req2", req_log[2], 32'h0000_1234);
        check("cwf_req3", req_log[3], 32'h0000_1235);
        check("cwf_fwd_pulses", fwd_n, 1);
        check("cwf_fwd_data", fwd_data_s, 32'h1236_EDC9);
`else
        check("linear_req0", req_log[0], 32'h0000_1234);
        check("linear_req3", req_log[3], 32'h0000_1237);
`endif

        // Backpressure: grant withheld for 5 cycles.
        lat = 2;
        start_miss(32'h0000_1234, 2'b00);
        force_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("bp_req%0d", i), s_req, 1);
            check($sformatf("bp_addr%0d", i), s_maddr, 32'h0000_1234);
            check($sformatf("bp_no_write%0d", i), s_we, 0);
        end
        force_stall = 1'b0;
        run_to_done(1'b0);
        verify(10, vecs[0]);

        // Reset after two responses, stale response, then fresh refill.
        lat = 2;
        start_miss(32'h0000_1234, 2'b00);
        for (int i = 0; i < 40 && wr_n < 2; i++) cycle();
        check("mid_writes_before_reset", wr_n, 2);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        pend_q.delete();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5A5A_5A5A;
        #1;
        check("post_reset_busy", busy_o, 0);
        check("post_reset_stale_we", data_we_o, 0);
        check("post_reset_outputs_or", |{done_o, mem_req_o, mem_addr_o, data_we_o, data_way_o,
              data_addr_o, data_wdata_o, tag_we_o, tag_way_o, tag_addr_o, tag_wdata_o}, 0);
        @(posedge clk_i);
        #1;
        cyc++;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        lat = vecs[6].lat;
        start_miss(vecs[6].addr, vecs[6].wv);
        run_to_done(1'b0);
        verify(6, vecs[6]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
